// File: rtl/prod_acc_pkg.sv
// Shared types and constants for the product accumulator: FSM state encoding,
// default widths and the saturation-limit helpers used when PROD_ACC_SAT_EN is defined.
package prod_acc_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAcc  = 2'd1,
        StHold = 2'd2
    } acc_state_e;

    localparam int unsigned DefWidth = 16;
    localparam int unsigned DefAccW  = 40;
    localparam int unsigned DefCntW  = 8;

    // Limits are built in a wide vector; callers keep the low ACC_W bits.
    localparam int unsigned MaxAccW = 128;

    function automatic logic [MaxAccW-1:0] sat_max(input int unsigned w);
        return (MaxAccW'(1) << (w - 1)) - MaxAccW'(1);
    endfunction

    function automatic logic [MaxAccW-1:0] sat_min(input int unsigned w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/prod_acc_add.sv
// Combinational signed ACC_W adder with overflow detect. Wraps by default;
// saturates to the signed limits when PROD_ACC_SAT_EN is defined.
module prod_acc_add
    import prod_acc_pkg::*;
#(
    parameter int unsigned ACC_W = DefAccW
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    logic [ACC_W-1:0] raw;

    always_comb begin
        raw = a + b;
        // Overflow only when both operands share a sign that the result lost.
        ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
    end

`ifdef PROD_ACC_SAT_EN
    localparam logic [MaxAccW-1:0] SatMaxWide = sat_max(ACC_W);
    localparam logic [MaxAccW-1:0] SatMinWide = sat_min(ACC_W);

    always_comb begin
        sum = raw;
        if (ovf) begin
            sum = a[ACC_W-1] ? SatMinWide[ACC_W-1:0] : SatMaxWide[ACC_W-1:0];
        end
    end
`else
    assign sum = raw;
`endif

endmodule

// File: rtl/prod_accumulator.sv
// Dot-product accumulator: sums signed products per group, presents the result in HOLD
// until taken. Overflow saturates instead of wrapping when PROD_ACC_SAT_EN is defined.
module prod_accumulator
    import prod_acc_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned ACC_W = DefAccW,
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   prod,
    input  logic                 in_last,
    input  logic                 acc_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_acc,
    output logic [CNT_W-1:0]     out_cnt,
    output logic                 ovf
);

    acc_state_e       state_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             out_valid_q;
    logic [ACC_W-1:0] out_acc_q;
    logic [CNT_W-1:0] out_cnt_q;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic             add_ovf;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;

    assign prod_ext = {{(ACC_W - 2*WIDTH){prod[2*WIDTH-1]}}, prod};
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign in_ready = (state_q != StHold);
    assign accept   = in_valid && in_ready;

    prod_acc_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .a   (acc_q),
        .b   (prod_ext),
        .sum (sum),
        .ovf (add_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_cnt_q   <= '0;
        end else begin
            case (state_q)
                StIdle, StAcc: begin
                    // Clear wins over a simultaneous product, which is dropped.
                    if (acc_clr) begin
                        state_q <= StIdle;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                    end else if (accept) begin
                        acc_q <= sum;
                        cnt_q <= cnt_inc;
                        ovf_q <= ovf_q | add_ovf;
                        if (in_last) begin
                            state_q     <= StHold;
                            out_valid_q <= 1'b1;
                            out_acc_q   <= sum;
                            out_cnt_q   <= cnt_inc;
                        end else begin
                            state_q <= StAcc;
                        end
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        ovf_q       <= 1'b0;
                        out_valid_q <= 1'b0;
                        out_acc_q   <= '0;
                        out_cnt_q   <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_cnt   = out_cnt_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_prod_accumulator.sv
// Scoreboard bench for prod_accumulator; the reference model follows PROD_ACC_SAT_EN.
module tb_prod_accumulator;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned ACC_W = 33;
    localparam int unsigned CNT_W = 8;
    localparam longint AccMax = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint AccMin = -(longint'(1) <<< (ACC_W - 1));

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [2*WIDTH-1:0] prod;
    logic               in_last;
    logic               acc_clr;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_acc;
    logic [CNT_W-1:0]   out_cnt;
    logic               ovf;

    typedef struct {
        logic [ACC_W-1:0] acc;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    longint m_acc;
    int     m_cnt;
    logic   m_ovf;

    prod_accumulator #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod      (prod),
        .in_last   (in_last),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_cnt   (out_cnt),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_acc = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    task automatic model_accept(input longint p, input logic last);
        longint           s;
        logic [ACC_W-1:0] t;
        exp_t             e;
        s = m_acc + p;
        if (s > AccMax || s < AccMin) begin
            m_ovf = 1'b1;
`ifdef PROD_ACC_SAT_EN
            s = (s > AccMax) ? AccMax : AccMin;
`else
            t = s[ACC_W-1:0];
            s = longint'($signed(t));
`endif
        end
        m_acc = s;
        m_cnt++;
        if (last) begin
            e.acc = m_acc[ACC_W-1:0];
            e.cnt = CNT_W'(m_cnt);
            e.ovf = m_ovf;
            sb.push_back(e);
            model_clear();
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input longint p, input logic last);
        int waited = 0;
        in_valid = 1'b1;
        prod     = (2*WIDTH)'(p);
        in_last  = last;
        while (!in_ready && waited < 50) begin
            step();
            waited++;
        end
        if (!in_ready) check_eq("in_ready_wait", 64'(in_ready), 64'(1));
        @(posedge clk);
        model_accept(p, last);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("sb_unexpected", 64'(sb.size()), 64'(1));
            end else begin
                e = sb.pop_front();
                check_eq("sb_acc", 64'(out_acc), 64'(e.acc));
                check_eq("sb_cnt", 64'(out_cnt), 64'(e.cnt));
                check_eq("sb_ovf", 64'(ovf), 64'(e.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        logic [ACC_W-1:0] exp_big;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        prod      = '0;
        in_last   = 1'b0;
        acc_clr   = 1'b0;
        out_ready = 1'b1;
        model_clear();
        #12;
        check_eq("rst_valid", 64'(out_valid), 64'(0));
        check_eq("rst_acc", 64'(out_acc), 64'(0));
        check_eq("rst_cnt", 64'(out_cnt), 64'(0));
        check_eq("rst_ovf", 64'(ovf), 64'(0));
        check_eq("rst_ready", 64'(in_ready), 64'(1));
        #3 rst_n = 1'b1;
        step();

        // Basic group plus back-pressure in HOLD
        out_ready = 1'b0;
        send(3, 1'b0);
        check_eq("a_no_early_valid", 64'(out_valid), 64'(0));
        send(-5, 1'b0);
        send(7, 1'b1);
        check_eq("a_lat_valid", 64'(out_valid), 64'(1));
        check_eq("a_lat_acc", 64'(out_acc), 64'(5));
        check_eq("a_lat_cnt", 64'(out_cnt), 64'(3));
        check_eq("a_lat_ovf", 64'(ovf), 64'(0));
        in_valid = 1'b1;
        prod     = 32'd99;
        in_last  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("a_hold_ready", 64'(in_ready), 64'(0));
            check_eq("a_hold_valid", 64'(out_valid), 64'(1));
            check_eq("a_hold_acc", 64'(out_acc), 64'(5));
            check_eq("a_hold_cnt", 64'(out_cnt), 64'(3));
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        step();
        check_eq("a_idle_valid", 64'(out_valid), 64'(0));
        check_eq("a_idle_ready", 64'(in_ready), 64'(1));
        check_eq("a_idle_acc", 64'(out_acc), 64'(0));

        // Clear discards the group and the simultaneous product
        send(20, 1'b0);
        check_eq("b_acc_hidden", 64'(out_acc), 64'(0));
        acc_clr  = 1'b1;
        in_valid = 1'b1;
        prod     = 32'd100;
        in_last  = 1'b1;
        check_eq("b_clr_ready", 64'(in_ready), 64'(1));
        step();
        acc_clr  = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_clear();
        check_eq("b_clr_no_valid", 64'(out_valid), 64'(0));
        send(1, 1'b1);
        check_eq("b_acc", 64'(out_acc), 64'(1));
        check_eq("b_cnt", 64'(out_cnt), 64'(1));
        step();

        // Positive overflow
        send(64'sh7FFF_FFFF, 1'b0);
        send(64'sh7FFF_FFFF, 1'b0);
        check_eq("c_no_ovf_yet", 64'(ovf), 64'(0));
        send(64'sh7FFF_FFFF, 1'b1);
        check_eq("c_ovf", 64'(ovf), 64'(1));
`ifdef PROD_ACC_SAT_EN
        exp_big = 33'h0_FFFF_FFFF;
`else
        exp_big = 33'h1_7FFF_FFFD;
`endif
        check_eq("c_acc", 64'(out_acc), 64'(exp_big));
        step();

        // Negative overflow
        send(-64'sd2147483648, 1'b0);
        send(-64'sd2147483648, 1'b0);
        send(-64'sd2147483648, 1'b1);
        check_eq("f_ovf", 64'(ovf), 64'(1));
        step();
        check_eq("f_ovf_cleared", 64'(ovf), 64'(0));

        // Asynchronous reset while a result is held
        out_ready = 1'b0;
        send(50, 1'b0);
        send(60, 1'b1);
        void'(sb.pop_back());
        #2 rst_n = 1'b0;
        #1;
        check_eq("d_rst_valid", 64'(out_valid), 64'(0));
        check_eq("d_rst_acc", 64'(out_acc), 64'(0));
        check_eq("d_rst_cnt", 64'(out_cnt), 64'(0));
        check_eq("d_rst_ready", 64'(in_ready), 64'(1));
        #2 rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        send(4, 1'b0);
        send(5, 1'b1);
        check_eq("d_acc", 64'(out_acc), 64'(9));
        check_eq("d_cnt", 64'(out_cnt), 64'(2));
        step();

        // Count wrap over 256 products
        for (int i = 0; i < 256; i++) begin
            send(longint'(i) * 131 - 16000, (i == 255));
        end
        check_eq("e_cnt_wrap", 64'(out_cnt), 64'(0));
        step();
        step();

        check_eq("sb_drained", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
